sub_sat_stage: RTL and testbench

Registered output stage for the signed n-bit subtractor. It consumes the (n+1)-bit difference and saturates it back to n bits, flagging any clipped sample. A 2-entry skid buffer with valid/ready handshake lets it sit in a streaming datapath at full throughput. It also keeps a saturating count of overflow events for software or debug readout.

---
 rtl/sub_sat_stage.sv | 149 ++++++++++++++
 tb/tb_sub_sat_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sub_sat_stage.sv
// sub_sat_stage: saturates an (n+1)-bit signed difference to n bits, flags
// clipped samples, and buffers them in a 2-entry skid buffer with a
// valid/ready handshake. Also keeps a saturating count of clipped samples.
module sub_sat_stage #(
    parameter int n  = 8,
    parameter int CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [n:0]   in_diff,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [n-1:0] out_data,
    output logic                out_ovf,
    input  logic                clr_count,
    output logic [CW-1:0]       ovf_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             state_next;
    logic               in_xfer;
    logic               out_xfer;
    logic               sat_ovf;
    logic signed [n-1:0] sat_data;
    logic signed [n-1:0] skid_data;
    logic               skid_ovf;
    logic               load_main;
    logic               load_skid;
    logic               move_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Overflow detection and clipping, done before either buffer entry is written.
    always_comb begin
        // NOTE: every signal written in always_comb gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        sat_ovf  = in_diff[n] ^ in_diff[n-1];
        sat_data = in_diff[n-1:0];
        if (sat_ovf) begin
            if (in_diff[n]) begin
                sat_data = {1'b1, {(n-1){1'b0}}};
            end else begin
                sat_data = {1'b0, {(n-1){1'b1}}};
            end
        end
    end

    // Buffer state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and buffer write enables.
    always_comb begin
        state_next = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    move_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Handshake flags are registered so in_ready never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_next != FULL);
            out_valid <= (state_next != EMPTY);
        end
    end

    // Main (output) register: loaded from the input or from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (load_main) begin
            out_data <= sat_data;
            out_ovf  <= sat_ovf;
        end else if (move_skid) begin
            out_data <= skid_data;
            out_ovf  <= skid_ovf;
        end
    end

    // Skid entry: captures the sample that arrives while main is stalled.
    always_ff @(posedge clk) begin
        // NOTE: the skid storage has no reset; its validity lives entirely in
        // the state register, so stale contents are never observable.
        if (load_skid) begin
            skid_data <= sat_data;
            skid_ovf  <= sat_ovf;
        end
    end

    // Saturating overflow event counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || clr_count) begin
            ovf_count <= '0;
        end else if (in_xfer && sat_ovf && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub_sat_stage.sv
// Scoreboard bench for sub_sat_stage. Two instances share stimulus: one with
// the default 16-bit counter and one with a 2-bit counter to reach saturation.
module tb_sub_sat_stage;

    localparam int N = 8;

    typedef struct packed {
        logic signed [N-1:0] data;
        logic                ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst       = 1'b1;
    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic                clr_count = 1'b0;
    logic signed [N:0]   in_diff   = '0;

    logic                in_ready_a, out_valid_a, out_ovf_a;
    logic signed [N-1:0] out_data_a;
    logic [15:0]         ovf_count_a;
    logic                in_ready_b, out_valid_b, out_ovf_b;
    logic signed [N-1:0] out_data_b;
    logic [1:0]          ovf_count_b;

    sub_sat_stage #(.n(N), .CW(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_diff(in_diff), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .out_ovf(out_ovf_a), .clr_count(clr_count),
        .ovf_count(ovf_count_a)
    );

    sub_sat_stage #(.n(N), .CW(2)) dut_cw2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_diff(in_diff), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .out_ovf(out_ovf_b), .clr_count(clr_count),
        .ovf_count(ovf_count_b)
    );

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt_a  = 0;
    int   cnt_b  = 0;

    // Decisions observed at the negedge, committed to the model at the next posedge.
    logic              pend_acc  = 1'b0;
    logic              pend_rst  = 1'b0;
    logic              pend_clr  = 1'b0;
    logic signed [N:0] pend_diff = '0;

    // Reference: clip to the n-bit signed range by plain arithmetic.
    function automatic exp_t model(input logic signed [N:0] d);
        exp_t e;
        int   v;
        v = int'(d);
        if (v > 127) begin
            e.data = 8'sd127;
            e.ovf  = 1'b1;
        end else if (v < -128) begin
            e.data = -8'sd128;
            e.ovf  = 1'b1;
        end else begin
            e.data = v[N-1:0];
            e.ovf  = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: commit last edge to the model, drive, then observe the handshake.
    task automatic cycle(input logic v, input int d, input logic ordy,
                         input logic clr, input logic r);
        @(posedge clk);
        if (pend_rst) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (pend_clr) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (pend_acc && model(pend_diff).ovf) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 3) cnt_b++;
        end
        if (pend_acc && !pend_rst) q.push_back(model(pend_diff));
        #1;
        rst       = r;
        in_valid  = v;
        in_diff   = d[N:0];
        out_ready = ordy;
        clr_count = clr;
        if (r) q.delete();
        @(negedge clk);
        pend_rst  = rst;
        pend_clr  = clr_count;
        pend_acc  = in_valid && in_ready_a && !rst;
        pend_diff = in_diff;
    endtask

    // Monitor: compares handshake flags, counters and any delivered sample.
    always @(negedge clk) begin
        if (!rst) begin
            check("ovf_count", int'(ovf_count_a), cnt_a);
            check("ovf_count_cw2", int'(ovf_count_b), cnt_b);
            check("out_valid", int'(out_valid_a), int'(q.size() > 0));
            check("in_ready", int'(in_ready_a), int'(q.size() < 2));
            check("in_ready_cw2", int'(in_ready_b), int'(in_ready_a));
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d with nothing expected at %0t",
                             out_data_a, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", int'(out_data_a), int'(e.data));
                    check("out_ovf", int'(out_ovf_a), int'(e.ovf));
                end
            end
        end
    end

    initial begin
        // Reset, then confirm reset values of the data outputs.
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check("reset_out_data", int'(out_data_a), 0);
        check("reset_out_ovf", int'(out_ovf_a), 0);

        // Pass-through and both clip directions.
        cycle(1, 7, 1, 0, 0);
        cycle(1, -11, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        cycle(1, 128, 1, 0, 0);
        cycle(1, -129, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        check("count_after_clips", int'(ovf_count_a), 2);

        // Backpressure: 1 and 2 accepted, 3 held until the buffer drains.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        check("bp_in_ready_low", int'(in_ready_a), 0);
        cycle(1, 3, 0, 0, 0);
        cycle(1, 3, 1, 0, 0);
        cycle(1, 3, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);

        // Counter saturation on the 2-bit instance, then clear beating an increment.
        cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 200, 1, 0, 0);
        cycle(1, 255, 1, 1, 0);
        cycle(0, 0, 1, 0, 0);
        check("clear_wins", int'(ovf_count_a), 0);

        // Reset while FULL: buffered samples must vanish.
        cycle(1, 300, 0, 0, 0);
        cycle(1, 6, 0, 0, 0);
        cycle(1, 9, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check("rst_out_valid", int'(out_valid_a), 0);
        check("rst_in_ready", int'(in_ready_a), 1);
        check("rst_ovf_count", int'(ovf_count_a), 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

        // Randomized traffic with occasional clear and reset.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 511)) - 256,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 199) == 0));
        end

        // Drain and confirm nothing remains outstanding.
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 0);
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
